axi4_lite_slave_regs: RTL

AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

---
 rtl/axi4_lite_slave_regs.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_slave_regs.sv
// rtl/axi4_lite_slave_regs.sv - AXI4-Lite slave exposing a bank of byte-strobed read/write registers
module axi4_lite_slave_regs #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDRESS_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDRESS_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int IDX_BITS   = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(NUM_REGS * STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
        $error("NUM_REGS must be a power of 2, at least 2");
    end

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    w_state_t                 w_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_WIDTH-1:0]    w_strb_q;
    logic [1:0]               bresp_q;

    logic                     latch_aw, latch_w, wr_commit;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [STRB_WIDTH-1:0]    wr_strb;
    logic                     wr_in_range;
    logic [IDX_BITS-1:0]      wr_idx;

    // The write that commits may take its address/data from the bus or from
    // whichever half was parked earlier, depending on which arrived first.
    always_comb begin
        w_state_nxt   = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        latch_aw      = 1'b0;
        latch_w       = 1'b0;
        wr_commit     = 1'b0;
        wr_addr       = aw_addr_q;
        wr_data       = w_data_q;
        wr_strb       = w_strb_q;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                wr_addr       = S_AXI_AWADDR;
                wr_data       = S_AXI_WDATA;
                wr_strb       = S_AXI_WSTRB;
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_commit   = 1'b1;
                    w_state_nxt = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    latch_aw    = 1'b1;
                    w_state_nxt = W_HAVE_ADDR;
                end else if (S_AXI_WVALID) begin
                    latch_w     = 1'b1;
                    w_state_nxt = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                S_AXI_WREADY = 1'b1;
                wr_data      = S_AXI_WDATA;
                wr_strb      = S_AXI_WSTRB;
                if (S_AXI_WVALID) begin
                    wr_commit   = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                S_AXI_AWREADY = 1'b1;
                wr_addr       = S_AXI_AWADDR;
                if (S_AXI_AWVALID) begin
                    wr_commit   = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign wr_in_range = {1'b0, wr_addr} < ADDR_LIMIT;
    assign wr_idx      = wr_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (latch_aw) begin
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (latch_w) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) begin
                bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit && wr_in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign S_AXI_BRESP = bresp_q;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    r_state_t              r_state, r_state_nxt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_accept;
    logic                  rd_in_range;
    logic [IDX_BITS-1:0]   rd_idx;

    always_comb begin
        r_state_nxt   = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        ar_accept     = 1'b0;
        if (r_state == R_IDLE) begin
            S_AXI_ARREADY = 1'b1;
            if (S_AXI_ARVALID) begin
                ar_accept   = 1'b1;
                r_state_nxt = R_DATA;
            end
        end else begin
            S_AXI_RVALID = 1'b1;
            if (S_AXI_RREADY) begin
                r_state_nxt = R_IDLE;
            end
        end
    end

    assign rd_in_range = {1'b0, S_AXI_ARADDR} < ADDR_LIMIT;
    assign rd_idx      = S_AXI_ARADDR[IDX_BITS+OFF_BITS-1:OFF_BITS];

    // Sampling regs on the accept edge yields the pre-write value when a
    // write to the same register commits on that same edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (ar_accept) begin
                rdata_q <= rd_in_range ? regs[rd_idx] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end

endmodule
